// File: rtl/exc_pkg.sv
// exc_pkg: shared types, defaults and the source-index width helper
// for the exception controller.  Rev 1.0
`default_nettype none

package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HANDLER = 2'd2
  } exc_state_t;

  localparam logic [63:0] EXC_VEC_BASE = 64'hD8;
  localparam int          EXC_ST_W     = 4;

  // Width of a source index; never narrower than one bit.
  function automatic int src_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: lowest-index-wins priority encoder over N request lines.
// Rev 1.0
`default_nettype none

module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  output logic [src_w(N)-1:0]   idx,
  output logic                  any
);

  localparam int W = src_w(N);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/exc_ctrl_n.sv
// exc_ctrl_n: N-source maskable exception controller with per-source vectors,
// ELR/ESR capture, fetch redirect and ERET return.  Rev 1.0
`default_nettype none

module exc_ctrl_n
  import exc_pkg::*;
#(
  parameter int                N_SRC      = 4,
  parameter int                ADDR_W     = 64,
  parameter int                ST_W       = EXC_ST_W,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(EXC_VEC_BASE),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = '0,
  localparam int               SRC_W      = src_w(N_SRC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_SRC-1:0]      exc_req,
  input  logic [N_SRC-1:0]      exc_mask,
  input  logic [ST_W-1:0]       estatus,
  input  logic [ADDR_W-1:0]     next_pc_f,
  input  logic [ADDR_W-1:0]     im_addr,
  input  logic                  eret,
  output logic                  eproc,
  output logic [ADDR_W-1:0]     vec_addr,
  output logic                  exc_ack,
  output logic                  ret_valid,
  output logic [ADDR_W-1:0]     elr,
  output logic [SRC_W+ST_W-1:0] esr,
  output logic [N_SRC-1:0]      pending,
  output logic                  in_handler,
  output logic                  eret_err
);

  exc_state_t       state, state_nx;
  logic [SRC_W-1:0] cur_src;
  logic [SRC_W-1:0] winner;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic             any_elig;
  logic             capture;

  assign elig = (pending | exc_req) & ~exc_mask;

  exc_prio_enc #(.N(N_SRC)) u_prio (
    .req (elig),
    .idx (winner),
    .any (any_elig)
  );

  // Driven from the registered source index only, so it never glitches.
  assign vec_addr = VEC_BASE + ADDR_W'(cur_src) * VEC_STRIDE;

  assign clr = exc_ack ? (N_SRC'(1) << cur_src) : '0;

  always_comb begin
    state_nx   = state;
    capture    = 1'b0;
    eproc      = 1'b0;
    exc_ack    = 1'b0;
    ret_valid  = 1'b0;
    eret_err   = 1'b0;
    in_handler = 1'b0;
    case (state)
      IDLE: begin
        eret_err = eret;
        if (any_elig) begin
          capture  = 1'b1;
          state_nx = PENDING;
        end
      end
      PENDING: begin
        eproc    = 1'b1;
        eret_err = eret;
        if (im_addr == vec_addr) begin
          exc_ack  = 1'b1;
          state_nx = HANDLER;
        end
      end
      HANDLER: begin
        in_handler = 1'b1;
        if (eret) begin
          ret_valid = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Reset aborts whatever is in flight without emitting ack or return.
    if (reset) begin
      capture    = 1'b0;
      eproc      = 1'b0;
      exc_ack    = 1'b0;
      ret_valid  = 1'b0;
      eret_err   = 1'b0;
      in_handler = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      elr     <= '0;
      esr     <= '0;
      cur_src <= '0;
    end else begin
      state   <= state_nx;
      pending <= (pending & ~clr) | exc_req;
      if (capture) begin
        elr     <= next_pc_f;
        esr     <= {winner, estatus};
        cur_src <= winner;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exc_ctrl_n.sv
// tb_exc_ctrl_n: directed scenarios plus randomized run against a behavioural
// model of the exception controller.  Rev 1.0
`default_nettype none

module tb_exc_ctrl_n;

  logic        clk, reset, eret;
  logic [3:0]  exc_req, exc_mask, estatus, pending;
  logic [63:0] next_pc_f, im_addr, vec_addr, elr;
  logic [5:0]  esr;
  logic        eproc, exc_ack, ret_valid, in_handler, eret_err;

  int checks = 0;
  int errors = 0;

  exc_ctrl_n #(
    .N_SRC(4), .ADDR_W(64), .ST_W(4), .VEC_BASE(64'hD8), .VEC_STRIDE(64'h80)
  ) dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_mask(exc_mask),
    .estatus(estatus), .next_pc_f(next_pc_f), .im_addr(im_addr), .eret(eret),
    .eproc(eproc), .vec_addr(vec_addr), .exc_ack(exc_ack), .ret_valid(ret_valid),
    .elr(elr), .esr(esr), .pending(pending), .in_handler(in_handler),
    .eret_err(eret_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: mode 0 = idle, 1 = awaiting fetch of vector, 2 = in handler.
  int          m_mode;
  int          m_src;
  logic [3:0]  m_pend;
  logic [63:0] m_elr;
  logic [5:0]  m_esr;

  function automatic logic [63:0] m_vec(input int s);
    return 64'hD8 + 64'(s) * 64'h80;
  endfunction

  task automatic model_step();
    logic [3:0] e;
    bit         ack;
    int         w;
    if (reset) begin
      m_mode = 0; m_src = 0; m_pend = '0; m_elr = '0; m_esr = '0;
    end else begin
      e   = (m_pend | exc_req) & ~exc_mask;
      ack = (m_mode == 1) && (im_addr == m_vec(m_src));
      if (ack) m_pend[m_src] = 1'b0;
      m_pend = m_pend | exc_req;
      if (m_mode == 0 && e != 0) begin
        w = 0;
        while (!e[w]) w++;
        m_elr  = next_pc_f;
        m_esr  = {2'(w), estatus};
        m_src  = w;
        m_mode = 1;
      end else if (m_mode == 1 && ack) begin
        m_mode = 2;
      end else if (m_mode == 2 && eret) begin
        m_mode = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; exc_req = '0; exc_mask = '0; eret = 1'b0;
    im_addr = '0; next_pc_f = '0; estatus = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; exc_req = 4'b1111; exc_mask = '0; eret = 1'b0;
    estatus = 4'h5; next_pc_f = 64'h1234; im_addr = 64'hD8;
    tick(); tick();
    #1;
    checks++; if ({eproc, exc_ack, ret_valid, in_handler, eret_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {eproc, exc_ack, ret_valid, in_handler, eret_err}); end
    checks++; if ({elr, esr, pending} !== '0) begin
      errors++; $display("FAIL reset_regs: elr=%h esr=%h pending=%b want all 0", elr, esr, pending); end
    reset = 1'b0;
    tick();
    #1;
    checks++; if (elr !== 64'h1234 || esr !== 6'h05 || eproc !== 1'b1) begin
      errors++; $display("FAIL reset_release: elr=%h esr=%h eproc=%b want 1234 05 1", elr, esr, eproc); end
  endtask

  task automatic test_vector();
    do_reset();
    exc_req = 4'b0100; next_pc_f = 64'h400; estatus = 4'h2;
    #1;
    checks++; if (eproc !== 1'b0) begin
      errors++; $display("FAIL vec_idle: eproc=%b want 0", eproc); end
    tick();
    exc_req = '0; next_pc_f = 64'h999;
    #1;
    checks++; if (eproc !== 1'b1 || vec_addr !== 64'h1D8 || exc_ack !== 1'b0) begin
      errors++; $display("FAIL vec_pending: eproc=%b vec=%h ack=%b want 1 1d8 0", eproc, vec_addr, exc_ack); end
    checks++; if (pending !== 4'b0100) begin
      errors++; $display("FAIL vec_pend_bit: got %b want 0100", pending); end
    im_addr = 64'h1D8;
    #1;
    checks++; if (exc_ack !== 1'b1) begin
      errors++; $display("FAIL vec_ack: got %b want 1", exc_ack); end
    tick();
    im_addr = '0;
    #1;
    checks++; if (pending !== 4'b0 || esr !== 6'b10_0010 || elr !== 64'h400 || in_handler !== 1'b1 || exc_ack !== 1'b0) begin
      errors++; $display("FAIL vec_handler: pend=%b esr=%b elr=%h inh=%b ack=%b", pending, esr, elr, in_handler, exc_ack); end
  endtask

  task automatic test_eret();
    do_reset();
    exc_req = 4'b0001; next_pc_f = 64'h400;
    tick();
    exc_req = '0; im_addr = 64'hD8;
    tick();
    im_addr = '0; eret = 1'b1;
    #1;
    checks++; if (ret_valid !== 1'b1 || elr !== 64'h400 || eret_err !== 1'b0) begin
      errors++; $display("FAIL eret_ret: ret=%b elr=%h err=%b want 1 400 0", ret_valid, elr, eret_err); end
    tick();
    #1;
    checks++; if (in_handler !== 1'b0 || eproc !== 1'b0 || ret_valid !== 1'b0 || eret_err !== 1'b1) begin
      errors++; $display("FAIL eret_idle: inh=%b eproc=%b ret=%b err=%b want 0 0 0 1", in_handler, eproc, ret_valid, eret_err); end
    tick();
    eret = 1'b0;
    #1;
    checks++; if (in_handler !== 1'b0 || eproc !== 1'b0 || eret_err !== 1'b0) begin
      errors++; $display("FAIL eret_nochange: inh=%b eproc=%b err=%b want 0 0 0", in_handler, eproc, eret_err); end
  endtask

  task automatic test_mask();
    do_reset();
    exc_req = 4'b1010; exc_mask = 4'b0010; estatus = 4'h7; next_pc_f = 64'h800;
    tick();
    exc_req = '0;
    #1;
    checks++; if (eproc !== 1'b1 || esr !== 6'b11_0111 || vec_addr !== 64'h258 || pending !== 4'b1010) begin
      errors++; $display("FAIL mask_take3: eproc=%b esr=%b vec=%h pend=%b", eproc, esr, vec_addr, pending); end
    im_addr = 64'h258;
    tick();
    #1;
    checks++; if (in_handler !== 1'b1 || pending !== 4'b0010) begin
      errors++; $display("FAIL mask_held: inh=%b pend=%b want 1 0010", in_handler, pending); end
    exc_mask = '0; eret = 1'b1; im_addr = '0;
    tick();
    eret = 1'b0;
    #1;
    checks++; if (eproc !== 1'b0 || in_handler !== 1'b0) begin
      errors++; $display("FAIL mask_gap: eproc=%b inh=%b want 0 0", eproc, in_handler); end
    tick();
    #1;
    checks++; if (eproc !== 1'b1 || esr[5:4] !== 2'd1 || vec_addr !== 64'h158) begin
      errors++; $display("FAIL mask_take1: eproc=%b src=%0d vec=%h want 1 1 158", eproc, esr[5:4], vec_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exc_req = 4'b0100;
    tick();
    im_addr = 64'h1D8;
    #1;
    checks++; if (exc_ack !== 1'b1) begin
      errors++; $display("FAIL b2b_ack: got %b want 1", exc_ack); end
    tick();
    exc_req = '0;
    #1;
    checks++; if (pending !== 4'b0100 || in_handler !== 1'b1) begin
      errors++; $display("FAIL b2b_setwins: pend=%b inh=%b want 0100 1", pending, in_handler); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1;
    checks++; if (eproc !== 1'b0 || in_handler !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: eproc=%b inh=%b want 0 0", eproc, in_handler); end
    tick();
    #1;
    checks++; if (eproc !== 1'b1 || esr[5:4] !== 2'd2 || exc_ack !== 1'b1) begin
      errors++; $display("FAIL b2b_reenter: eproc=%b src=%0d ack=%b want 1 2 1", eproc, esr[5:4], exc_ack); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    exc_req = 4'b0010; next_pc_f = 64'h55;
    tick();
    exc_req = '0;
    #1;
    checks++; if (eproc !== 1'b1) begin
      errors++; $display("FAIL rstp_pending: eproc=%b want 1", eproc); end
    im_addr = 64'h158; reset = 1'b1;
    #1;
    checks++; if (exc_ack !== 1'b0) begin
      errors++; $display("FAIL rstp_noack: got %b want 0", exc_ack); end
    tick();
    reset = 1'b0; im_addr = '0;
    #1;
    checks++; if (eproc !== 1'b0 || in_handler !== 1'b0 || pending !== 4'b0 || elr !== 64'h0) begin
      errors++; $display("FAIL rstp_after: eproc=%b inh=%b pend=%b elr=%h want 0 0 0 0", eproc, in_handler, pending, elr); end
  endtask

  task automatic test_random();
    logic [63:0] e_vec;
    bit          e_rst_n;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 79) == 0);
      exc_req   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      exc_mask  = 4'($urandom) & 4'($urandom);
      estatus   = 4'($urandom);
      next_pc_f = {$urandom, $urandom};
      eret      = ($urandom_range(0, 5) == 0);
      if (m_mode == 1 && $urandom_range(0, 2) != 0) im_addr = m_vec(m_src);
      else im_addr = {$urandom, $urandom};
      #1;
      e_rst_n = !reset;
      e_vec   = m_vec(m_src);
      checks++; if (vec_addr !== e_vec) begin
        errors++; $display("FAIL rnd_vec[%0d]: got %h want %h", n, vec_addr, e_vec); end
      checks++; if (eproc !== (e_rst_n && m_mode == 1) || in_handler !== (e_rst_n && m_mode == 2)) begin
        errors++; $display("FAIL rnd_state[%0d]: eproc=%b inh=%b model_mode=%0d", n, eproc, in_handler, m_mode); end
      checks++; if (exc_ack !== (e_rst_n && m_mode == 1 && im_addr == e_vec)) begin
        errors++; $display("FAIL rnd_ack[%0d]: got %b", n, exc_ack); end
      checks++; if (ret_valid !== (e_rst_n && m_mode == 2 && eret) || eret_err !== (e_rst_n && m_mode != 2 && eret)) begin
        errors++; $display("FAIL rnd_eret[%0d]: ret=%b err=%b mode=%0d eret=%b", n, ret_valid, eret_err, m_mode, eret); end
      checks++; if (elr !== m_elr || esr !== m_esr || pending !== m_pend) begin
        errors++; $display("FAIL rnd_regs[%0d]: elr=%h/%h esr=%h/%h pend=%b/%b", n, elr, m_elr, esr, m_esr, pending, m_pend); end
      tick();
    end
  endtask

  initial begin
    m_mode = 0; m_src = 0; m_pend = '0; m_elr = '0; m_esr = '0;
    test_reset();
    test_vector();
    test_eret();
    test_mask();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exc_ctrl_n.md
Name: exc_ctrl_n

Overview:
Parametrised exception controller for the LEGv8 datapath. Generalises the single-source Exc/ERet path to N_SRC maskable sources with fixed priority and per-source vectors. Captures the return address (ELR) and a syndrome (ESR), redirects fetch to the vector, and acknowledges when fetch reaches the vector. Restores PC on ERET. Sits beside the fetch stage and drives the PC-select mux.

Parameters:
N_SRC, 4, number of exception sources; index 0 has the highest priority.
ADDR_W, 64, PC/address width.
ST_W, 4, width of the status code captured from the core.
VEC_BASE, 64'hD8, vector address of source 0.
VEC_STRIDE, 64'h0, byte spacing between source vectors; 0 makes all sources share VEC_BASE.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
exc_req  in  N_SRC  level request per source.
exc_mask  in  N_SRC  1 = source masked (request is held pending, never taken).
estatus  in  ST_W  status code, sampled at capture.
next_pc_f  in  ADDR_W  return address, sampled at capture.
im_addr  in  ADDR_W  current fetch address.
eret  in  1  ERET executing this cycle.
eproc  out  1  redirect-to-vector active (state PENDING).
vec_addr  out  ADDR_W  VEC_BASE + cur_src*VEC_STRIDE, modulo 2^ADDR_W.
exc_ack  out  1  one-cycle pulse: fetch reached the vector.
ret_valid  out  1  one-cycle pulse: redirect PC to elr.
elr  out  ADDR_W  saved return address.
esr  out  SRC_W+ST_W  saved syndrome, {cur_src, estatus}.
pending  out  N_SRC  pending-request register.
in_handler  out  1  state == HANDLER.
eret_err  out  1  one-cycle pulse: eret seen outside HANDLER.

Behaviour:
- SRC_W = max(1, $clog2(N_SRC)).
- Reset (synchronous, active-high): state=IDLE; pending, elr, esr and cur_src = 0; all pulses = 0. Reset mid-operation aborts any state with no ack or ret pulse.
- Pending update every cycle: pending <= (pending & ~clr) | exc_req. clr is the one-hot of cur_src on the exc_ack cycle, else 0. A request arriving on the same cycle as its own clear stays pending, because set wins.
- Eligible set: elig = (pending | exc_req) & ~exc_mask. Winner = lowest set index of elig.
- IDLE:
  - If elig != 0: capture elr<=next_pc_f, esr<={winner, estatus}, cur_src<=winner; go to PENDING.
  - Latency: a request at cycle t gives eproc=1 at t+1.
- PENDING:
  - eproc=1; vec_addr is valid.
  - When im_addr == vec_addr: exc_ack=1 this cycle (combinational), clear pending[cur_src], go to HANDLER.
  - Otherwise stay in PENDING.
- HANDLER:
  - No nesting: new requests accumulate in pending only.
  - On eret=1: ret_valid=1 this cycle (combinational), go to IDLE.
  - A source still eligible is taken on the next cycle. That gives back-to-back handling with one IDLE cycle.
- eret in IDLE or PENDING: ignored for state; eret_err=1 for that cycle.
- elr and esr are held stable from capture until the next capture.
- Masking a source after capture does not cancel the exception in progress.
- vec_addr is computed from the registered cur_src, so it is glitch-free within a cycle.

Decomposition:
- Package exc_pkg holds:
  - enum exc_state_t {IDLE, PENDING, HANDLER} (2 bits);
  - default constants EXC_VEC_BASE=64'hD8 and EXC_ST_W=4;
  - the SRC_W helper function.
- Sub-module exc_prio_enc #(N): combinational lowest-index priority encoder with outputs idx and any.
- The controller FSM and registers live in exc_ctrl_n.

Test Plan:
- Reset with exc_req=4'b1111 asserted → all outputs 0 and state IDLE during reset. The cycle after release: elr captured, esr={0, estatus}.
- exc_req=4'b0100 at cycle t, next_pc_f=0x400, estatus=4'h2, VEC_STRIDE=0x80 → at t+1 eproc=1 and vec_addr=0x1D8. Then im_addr=0x1D8 → exc_ack pulse, pending[2]=0, esr=6'b10_0010, elr=0x400.
- exc_req=4'b1010 with exc_mask=4'b0010 → source 3 is taken. pending[1] stays set; after eret, source 1 is taken once exc_mask=0.
- In HANDLER, eret=1 with elr=0x400 → ret_valid=1 the same cycle and state IDLE next cycle. eret=1 in IDLE → eret_err pulse, no state change.
- On the exc_ack cycle, re-assert exc_req[cur_src] → pending bit stays set. After eret, the same source is re-entered with one IDLE cycle between.
- reset asserted in PENDING → no exc_ack, state IDLE, pending cleared.
